lsu_mem_ctrl: RTL and testbench

- Load/store unit directly downstream of the ALU.
- Consumes the ALU result as the effective address and the rs2 value as store data.
- Runs a request/grant/response transaction on the data-memory port.
- Returns sign/zero-extended load data to writeback.
- Holds `stall` high while a transaction is in flight, which freezes PC and pipeline state in the single-cycle core.

---
 rtl/lsu_mem_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: request/grant/response bus FSM with lane steering and load extension.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned H/W accesses complete with err, no bus access.
module lsu_mem_ctrl #(
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              mem_op,
   input  logic              mem_we,
   input  logic [2:0]        funct3,
   input  logic [ADDR_W-1:0] eff_addr,
   input  logic [31:0]       store_data,
   output logic              stall,
   output logic              done,
   output logic [31:0]       load_data,
   output logic              err,
   output logic              mem_req,
   input  logic              mem_gnt,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_wen,
   output logic [31:0]       mem_wdata,
   output logic [3:0]        mem_wstrb,
   input  logic              mem_rvalid,
   input  logic [31:0]       mem_rdata
);

   typedef enum logic [1:0] {
      S_IDLE, S_REQ, S_WAIT, S_DONE
   } state_t;

   localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

   state_t            state_q, state_d;
   logic [15:0]       cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q;
   logic              we_q;
   logic [2:0]        f3_q;
   logic [1:0]        off_q;
   logic [31:0]       wdata_q;
   logic [3:0]        wstrb_q;
   logic [31:0]       ld_q;
   logic              err_q;

   logic [1:0]  size;
   logic [1:0]  off;
   logic        illegal;
   logic        bad;
   logic [31:0] lane_wd;
   logic [3:0]  lane_st;
   logic        tmo;
   logic        fin;
   logic        fin_err;
   logic        ld_cap;
   logic [31:0] sh;
   logic [31:0] ext;

   assign size = funct3[1:0];
   assign tmo  = (cnt_q == TO_LAST);

   // Classify the incoming request and steer store data onto byte lanes
   always_comb begin
      if (mem_we) begin
         illegal = funct3[2] | (size == 2'b11);
      end else begin
         illegal = (size == 2'b11) | (funct3 == 3'b110);
      end
`ifdef LSU_MISALIGN_TRAP_EN
      bad = illegal
          | ((size == 2'b01) & eff_addr[0])
          | ((size == 2'b10) & (eff_addr[1:0] != 2'b00));
`else
      bad = illegal;
`endif
      unique case (1'b1)
         size == 2'b00: begin
            off     = eff_addr[1:0];
            lane_wd = {4{store_data[7:0]}};
            lane_st = 4'b0001 << off;
         end
         size == 2'b01: begin
            off     = {eff_addr[1], 1'b0};
            lane_wd = {2{store_data[15:0]}};
            lane_st = 4'b0011 << off;
         end
         default: begin
            off     = 2'b00;
            lane_wd = store_data;
            lane_st = 4'b1111;
         end
      endcase
   end

   // Pick the addressed byte/half of the response and extend it
   always_comb begin
      sh = mem_rdata >> {off_q, 3'b000};
      unique case (1'b1)
         f3_q == 3'b000: ext = {{24{sh[7]}}, sh[7:0]};
         f3_q == 3'b100: ext = {24'h0, sh[7:0]};
         f3_q == 3'b001: ext = {{16{sh[15]}}, sh[15:0]};
         f3_q == 3'b101: ext = {16'h0, sh[15:0]};
         default:        ext = mem_rdata;
      endcase
   end

   // State and timeout counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state; timeout wins over a grant, a response wins over timeout
   always_comb begin
      state_d = state_q;
      fin_err = 1'b0;
      ld_cap  = 1'b0;
      cnt_d   = '0;
      unique case (state_q)
         S_IDLE: begin
            if (mem_op) begin
               state_d = bad ? S_DONE : S_REQ;
               fin_err = bad;
            end
         end
         S_REQ: begin
            cnt_d = cnt_q + 16'd1;
            if (tmo) begin
               state_d = S_DONE;
               fin_err = 1'b1;
            end else if (mem_gnt) begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q + 16'd1;
            if (mem_rvalid) begin
               state_d = S_DONE;
               ld_cap  = !we_q;
            end else if (tmo) begin
               state_d = S_DONE;
               fin_err = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
      fin = (state_d == S_DONE) && (state_q != S_DONE);
   end

   // Core-facing and bus-facing controls decoded from state
   always_comb begin
      stall   = ((state_q == S_IDLE) & mem_op & rst_n)
              | (state_q == S_REQ) | (state_q == S_WAIT);
      done    = (state_q == S_DONE);
      mem_req = (state_q == S_REQ);
      mem_wen = we_q & (state_q == S_REQ);
   end

   // Latch the request in IDLE and the result on entry to DONE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q  <= '0;
         we_q    <= 1'b0;
         f3_q    <= 3'b000;
         off_q   <= 2'b00;
         wdata_q <= '0;
         wstrb_q <= '0;
         ld_q    <= '0;
         err_q   <= 1'b0;
      end else begin
         if ((state_q == S_IDLE) && mem_op) begin
            addr_q  <= {eff_addr[ADDR_W-1:2], 2'b00};
            we_q    <= mem_we;
            f3_q    <= funct3;
            off_q   <= off;
            wdata_q <= lane_wd;
            wstrb_q <= lane_st;
         end
         if (fin) begin
            err_q <= fin_err;
            if (ld_cap) begin
               ld_q <= ext;
            end
         end
      end
   end

   assign load_data = ld_q;
   assign err       = err_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign mem_wstrb = wstrb_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Randomized bench for lsu_mem_ctrl against a transaction-level model.
// Model follows LSU_MISALIGN_TRAP_EN the same way the design build does.
module tb_lsu_mem_ctrl;

   localparam int TO = 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mem_op;
   logic        mem_we;
   logic [2:0]  funct3;
   logic [31:0] eff_addr;
   logic [31:0] store_data;
   logic        stall;
   logic        done;
   logic [31:0] load_data;
   logic        err;
   logic        mem_req;
   logic        mem_gnt;
   logic [31:0] mem_addr;
   logic        mem_wen;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;

   int n_cmp = 0;
   int n_bad = 0;
   logic [31:0] exp_ld = 32'h0;

`ifdef LSU_MISALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   lsu_mem_ctrl #(.ADDR_W(32), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .mem_op(mem_op), .mem_we(mem_we), .funct3(funct3),
      .eff_addr(eff_addr), .store_data(store_data),
      .stall(stall), .done(done), .load_data(load_data), .err(err),
      .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_addr(mem_addr),
      .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] want);
      n_cmp++;
      if (obs !== want) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, obs, want);
      end
   endtask

   function automatic int m_nb(input logic [2:0] f3);
      if (f3[1:0] == 2'b00) return 1;
      if (f3[1:0] == 2'b01) return 2;
      return 4;
   endfunction

   function automatic bit m_bad(input logic we, input logic [2:0] f3,
                                input logic [31:0] a);
      bit ill;
      if (we) ill = !(f3 inside {3'b000, 3'b001, 3'b010});
      else    ill = f3 inside {3'b011, 3'b110, 3'b111};
      return ill || (TRAP && (int'(a[1:0]) % m_nb(f3) != 0));
   endfunction

   function automatic logic [31:0] m_load(input logic [2:0] f3,
                                          input logic [31:0] a,
                                          input logic [31:0] rd);
      int nb = m_nb(f3);
      int o = (int'(a[1:0]) / nb) * nb;
      logic [31:0] v, mask;
      v = rd >> (8 * o);
      if (nb < 4) begin
         mask = (32'h1 << (8 * nb)) - 32'h1;
         v = v & mask;
         if (!f3[2] && v[8*nb-1]) v = v | ~mask;
      end
      return v;
   endfunction

   task automatic txn(input logic we, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] sd,
                      input logic [31:0] rd, input int g, input int r);
      int nb, o, dc, ereq, reqc, waitc, got, seen;
      bit bad, eerr, granted;
      logic [31:0] wd;
      logic [3:0] st;
      nb = m_nb(f3);
      o = (int'(a[1:0]) / nb) * nb;
      for (int i = 0; i < 4; i++) begin
         wd[8*i +: 8] = sd[8*(i % nb) +: 8];
         st[i] = (i >= o) && (i < o + nb);
      end
      bad = m_bad(we, f3, a);
      if (bad) begin
         dc = 1; eerr = 1'b1; ereq = 0;
      end else if (g + r + 2 > TO) begin
         dc = TO + 1; eerr = 1'b1; ereq = (g + 1 < TO) ? g + 1 : TO;
      end else begin
         dc = g + r + 3; eerr = 1'b0; ereq = g + 1;
      end
      @(negedge clk);
      mem_op = 1'b1; mem_we = we; funct3 = f3;
      eff_addr = a; store_data = sd;
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      #1 chk("stall_idle", stall, 1);
      reqc = 0; waitc = 0; got = 0; seen = 0; granted = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (done) begin
            got = k;
            break;
         end
         chk("stall_busy", stall, 1);
         if (mem_req) begin
            seen++;
            chk("addr", mem_addr, {a[31:2], 2'b00});
            chk("wen", mem_wen, we);
            if (we) begin
               chk("wstrb", mem_wstrb, st);
               chk("wdata", mem_wdata, wd);
            end
            reqc++;
            mem_gnt = (reqc == g + 1);
            if (mem_gnt) granted = 1'b1;
            mem_rvalid = $urandom_range(0, 1) == 1;
            mem_rdata = $urandom;
         end else begin
            mem_gnt = 1'b0;
            if (granted) waitc++;
            mem_rvalid = granted && (waitc == r + 1);
            mem_rdata = mem_rvalid ? rd : $urandom;
         end
      end
      chk("done_cycle", got, dc);
      chk("req_cycles", seen, ereq);
      if (got != 0) begin
         chk("stall_done", stall, 0);
         chk("err", err, eerr);
         if (!eerr && !we) exp_ld = m_load(f3, a, rd);
         chk("load_data", load_data, exp_ld);
      end
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      @(negedge clk);
      chk("no_reaccept", mem_req, 0);
      chk("done_pulse", done, 0);
      mem_op = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; mem_op = 1'b0; mem_we = 1'b0; funct3 = 3'b000;
      eff_addr = '0; store_data = '0; mem_gnt = 1'b0;
      mem_rvalid = 1'b0; mem_rdata = '0;
      #1;
      chk("rst_stall", stall, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_req", mem_req, 0);
      chk("rst_ld", load_data, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_wstrb", mem_wstrb, 0);
      chk("rst_wdata", mem_wdata, 0);
      chk("rst_wen", mem_wen, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      txn(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0);
      chk("lw_const", load_data, 32'hDEADBEEF);
      txn(1'b0, 3'b000, 32'h203, 32'h0, 32'h80FF1234, 0, 0);
      chk("lb_const", load_data, 32'hFFFFFF80);
      txn(1'b0, 3'b100, 32'h203, 32'h0, 32'h80FF1234, 1, 0);
      chk("lbu_const", load_data, 32'h00000080);
      txn(1'b0, 3'b001, 32'h202, 32'h0, 32'h80FF1234, 0, 1);
      chk("lh_const", load_data, 32'hFFFF80FF);
      txn(1'b1, 3'b000, 32'h41, 32'hAB, 32'h5555AAAA, 0, 0);
      txn(1'b1, 3'b001, 32'h42, 32'h1234, 32'h0, 1, 1);
      txn(1'b0, 3'b010, 32'h300, 32'h0, 32'h13579BDF, 3, 1);
      txn(1'b0, 3'b010, 32'h400, 32'h0, 32'h11111111, 20, 0);
      chk("tmo_req", mem_req, 0);
      txn(1'b1, 3'b010, 32'h404, 32'hCAFEF00D, 32'h0, 2, 10);
      txn(1'b0, 3'b010, 32'h102, 32'h0, 32'hA5A5C3C3, 0, 0);
      txn(1'b0, 3'b011, 32'h500, 32'h0, 32'h0, 0, 0);
      txn(1'b1, 3'b100, 32'h504, 32'h77, 32'h0, 0, 0);
      txn(1'b0, 3'b101, 32'h603, 32'h0, 32'hFEDC8765, 0, 2);

      // reset in the middle of WAIT, then a stale response
      @(negedge clk);
      mem_op = 1'b1; mem_we = 1'b0; funct3 = 3'b010; eff_addr = 32'h700;
      @(negedge clk);
      chk("rw_req", mem_req, 1);
      mem_gnt = 1'b1;
      @(negedge clk);
      mem_gnt = 1'b0;
      chk("rw_wait_stall", stall, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("rw_req_drop", mem_req, 0);
      chk("rw_stall_drop", stall, 0);
      chk("rw_done", done, 0);
      chk("rw_ld", load_data, 0);
      chk("rw_addr", mem_addr, 0);
      exp_ld = 32'h0;
      @(negedge clk);
      rst_n = 1'b1; mem_op = 1'b0;
      mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
      @(negedge clk);
      mem_rvalid = 1'b0;
      chk("late_stall", stall, 0);
      chk("late_req", mem_req, 0);
      chk("late_done", done, 0);
      @(negedge clk);
      chk("late_done2", done, 0);
      chk("late_ld", load_data, 0);

      for (int n = 0; n < 80; n++) begin
         logic [31:0] a;
         a = {16'h0, 16'($urandom)};
         txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a,
             $urandom, $urandom, $urandom_range(0, 4),
             $urandom_range(0, 4));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
